// File: rtl/slot_alloc.sv
// -----------------------------------------------------------------------------
// slot_alloc
//   Free-slot allocator for a WIDTH-entry out-of-order buffer. Grants the
//   lowest-index free slot each cycle (valid/ready), tracks per-slot busy bits,
//   and releases slots by mask. A flush releases every slot.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_alloc_valid   requester wants a slot this cycle
//   o_alloc_ready   a slot is available and no flush (combinational)
//   o_alloc_sel     one-hot granted slot, 0 when not ready (combinational)
//   o_alloc_idx     binary index of o_alloc_sel, 0 when not ready (combinational)
//   i_free_valid    release the slots in i_free_mask this cycle
//   i_free_mask     slots to release
//   i_flush         release all slots and cancel allocation
//   o_busy          registered per-slot busy vector
//   o_count         registered popcount of o_busy
//   o_full/o_empty  count == WIDTH / count == 0
//   o_err           sticky: a free of a non-busy slot was seen
// -----------------------------------------------------------------------------
module slot_alloc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDXW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alloc_valid,
  output logic              o_alloc_ready,
  output logic [WIDTH-1:0]  o_alloc_sel,
  output logic [IDXW-1:0]   o_alloc_idx,
  input  logic              i_free_valid,
  input  logic [WIDTH-1:0]  i_free_mask,
  input  logic              i_flush,
  output logic [WIDTH-1:0]  o_busy,
  output logic [IDXW:0]     o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam int unsigned CW = IDXW + 1;

  logic [WIDTH-1:0] r_busy;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic [WIDTH-1:0] w_avail;
  logic [WIDTH-1:0] w_low;
  logic [WIDTH-1:0] w_grant;
  logic [WIDTH-1:0] w_rel;
  logic [CW-1:0]    w_rel_cnt;
  logic [IDXW-1:0]  w_idx;
  logic             w_fire;
  logic             w_bad;

  // Lowest set bit of the free vector: x & -x
  assign w_avail = ~r_busy;
  assign w_low   = w_avail & (~w_avail + WIDTH'(1));

  assign o_alloc_ready = ~i_flush & (|w_avail);
  assign o_alloc_sel   = o_alloc_ready ? w_low : '0;
  assign w_fire        = i_alloc_valid & o_alloc_ready;
  assign w_grant       = w_fire ? w_low : '0;

  // One-hot to binary
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (o_alloc_sel[i]) w_idx = IDXW'(i);
    end
  end
  assign o_alloc_idx = w_idx;

  // Only currently busy slots are released; other mask bits flag an error
  assign w_rel = i_free_valid ? (i_free_mask & r_busy) : '0;
  assign w_bad = i_free_valid & ~i_flush & (|(i_free_mask & w_avail));

  always_comb begin
    w_rel_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_rel_cnt = w_rel_cnt + CW'(w_rel[i]);
    end
  end

  // Busy/count/err state; flush beats alloc and free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_flush) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= (r_busy & ~w_rel) | w_grant;
      r_count <= r_count + CW'(w_fire) - w_rel_cnt;
      r_err   <= r_err | w_bad;
    end
  end

  assign o_busy  = r_busy;
  assign o_count = r_count;
  assign o_err   = r_err;
  assign o_full  = (r_count == CW'(WIDTH));
  assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_slot_alloc.sv
module tb_slot_alloc;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [W-1:0]  alloc_sel;
  logic [3:0]    alloc_idx;
  logic          free_valid;
  logic [W-1:0]  free_mask;
  logic          flush;
  logic [W-1:0]  busy;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  slot_alloc #(.WIDTH(16), .IDXW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_valid (alloc_valid),
    .o_alloc_ready (alloc_ready),
    .o_alloc_sel   (alloc_sel),
    .o_alloc_idx   (alloc_idx),
    .i_free_valid  (free_valid),
    .i_free_mask   (free_mask),
    .i_flush       (flush),
    .o_busy        (busy),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          av;
    bit          fv;
    logic [15:0] m;
    bit          fl;
    bit          c;     // check combinational grant outputs before the edge
    bit          e_rdy;
    int          e_idx;
    logic [15:0] e_busy;
    int          e_cnt;
    bit          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit av, bit fv, logic [15:0] m, bit fl, bit c,
                              bit e_rdy, int e_idx, logic [15:0] e_busy, int e_cnt, bit e_err);
    vec_t v;
    v.r = r; v.av = av; v.fv = fv; v.m = m; v.fl = fl; v.c = c;
    v.e_rdy = e_rdy; v.e_idx = e_idx; v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [15:0] ones(int n);
    logic [31:0] t;
    t = (32'd1 << n) - 32'd1;
    return t[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit av, bit fv, logic [15:0] m, bit fl);
    rst = r; alloc_valid = av; free_valid = fv; free_mask = m; flush = fl;
  endtask

  // Reference model state
  bit m_b[W];
  bit m_err;

  function automatic int m_first_free();
    for (int i = 0; i < W; i++) if (!m_b[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(m_b[i]);
    return n;
  endfunction

  function automatic logic [15:0] m_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < W; i++) v[i] = m_b[i];
    return v;
  endfunction

  initial begin
    drive(1, 0, 0, 16'h0, 0);

    // 1: fill from reset, then alloc while full is ignored
    vecs.push_back(mk(1,0,0,16'h0,0, 0, 0,0,16'h0000,0,0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,i,ones(i+1),i+1,0));
    vecs.push_back(mk(0,1,0,16'h0,0, 1, 0,0,16'hFFFF,16,0));
    // 2: free two from full, refill lowest first
    vecs.push_back(mk(0,0,1,16'h0024,0, 1, 0,0,16'hFFDB,14,0));
    vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,2,16'hFFDF,15,0));
    vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,5,16'hFFFF,16,0));
    // 3: same-cycle alloc and free; freed slot not granted until next cycle
    vecs.push_back(mk(1,0,0,16'h0,0, 0, 0,0,16'h0000,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,i,ones(i+1),i+1,0));
    vecs.push_back(mk(0,1,1,16'h0008,0, 1, 1,4,16'h0017,4,0));
    vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,3,16'h001F,5,0));
    // 4: invalid free sets sticky err, valid bit still freed
    vecs.push_back(mk(1,0,0,16'h0,0, 0, 0,0,16'h0000,0,0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,i,ones(i+1),i+1,0));
    vecs.push_back(mk(0,0,1,16'h0006,0, 1, 1,2,16'h0001,1,1));
    vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,1,16'h0003,2,1));
    for (int i = 2; i < 8; i++)
      vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,i,ones(i+1),i+1,1));
    // 5: flush with alloc and free pending: no grant, err held
    vecs.push_back(mk(0,1,1,16'h0001,1, 1, 0,0,16'h0000,0,1));
    // 6: rst mid-stream clears err and busy
    for (int i = 0; i < 12; i++)
      vecs.push_back(mk(0,1,0,16'h0,0, 1, 1,i,ones(i+1),i+1,1));
    vecs.push_back(mk(0,0,1,16'h00F0,0, 1, 1,12,16'h0F0F,8,1));
    vecs.push_back(mk(1,1,0,16'h0,0, 0, 0,0,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,16'h0,0, 1, 1,0,16'h0000,0,0));

    foreach (vecs[k]) begin
      vec_t v;
      logic [15:0] es;
      v = vecs[k];
      @(negedge clk);
      drive(v.r, v.av, v.fv, v.m, v.fl);
      #1;
      if (v.c) begin
        es = v.e_rdy ? (16'h1 << v.e_idx) : 16'h0;
        chk($sformatf("vec%0d ready", k), 32'(alloc_ready), 32'(v.e_rdy));
        chk($sformatf("vec%0d idx", k),   32'(alloc_idx),   32'(v.e_idx));
        chk($sformatf("vec%0d sel", k),   32'(alloc_sel),   32'(es));
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy", k),  32'(busy),  32'(v.e_busy));
      chk($sformatf("vec%0d count", k), 32'(count), 32'(v.e_cnt));
      chk($sformatf("vec%0d full", k),  32'(full),  32'(v.e_cnt == 16));
      chk($sformatf("vec%0d empty", k), 32'(empty), 32'(v.e_cnt == 0));
      chk($sformatf("vec%0d err", k),   32'(err),   32'(v.e_err));
    end

    // Random phase; DUT is in the reset-equivalent state here
    for (int i = 0; i < W; i++) m_b[i] = 1'b0;
    m_err = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, av, fv, fl, e_rdy;
      logic [15:0] m, e_sel;
      int e_idx, ff;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 39) == 0);
      av = ($urandom_range(0, 9) < 6);
      fv = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0: m = 16'($urandom) & 16'($urandom);
        1: m = 16'h1 << $urandom_range(0, 15);
        default: begin
          m = '0;
          for (int i = 0; i < W; i++) if (m_b[i] && $urandom_range(0, 2) == 0) m[i] = 1'b1;
        end
      endcase

      @(negedge clk);
      drive(r, av, fv, m, fl);
      #1;
      ff    = m_first_free();
      e_rdy = !fl && (ff >= 0);
      e_idx = e_rdy ? ff : 0;
      e_sel = e_rdy ? (16'h1 << ff) : 16'h0;
      chk("rnd ready", 32'(alloc_ready), 32'(e_rdy));
      chk("rnd idx",   32'(alloc_idx),   32'(e_idx));
      chk("rnd sel",   32'(alloc_sel),   32'(e_sel));

      if (r) begin
        for (int i = 0; i < W; i++) m_b[i] = 1'b0;
        m_err = 1'b0;
      end else if (fl) begin
        for (int i = 0; i < W; i++) m_b[i] = 1'b0;
      end else begin
        if (fv)
          for (int i = 0; i < W; i++)
            if (m[i]) begin
              if (m_b[i]) m_b[i] = 1'b0;
              else        m_err  = 1'b1;
            end
        if (av && e_rdy) m_b[ff] = 1'b1;
      end

      @(posedge clk); #1;
      chk("rnd busy",  32'(busy),  32'(m_vec()));
      chk("rnd count", 32'(count), 32'(m_count()));
      chk("rnd full",  32'(full),  32'(m_count() == W));
      chk("rnd empty", 32'(empty), 32'(m_count() == 0));
      chk("rnd err",   32'(err),   32'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
